// File: rtl/rename_pkg.sv
// Shared rename-stage types: decoded/renamed instruction payloads and writeback/commit/branch buses.
package rename_pkg;

  localparam int unsigned ARCH_REGS = 32;
  localparam int unsigned PHYS_REGS = 64;
  localparam int unsigned NUM_CKPT  = 4;

  localparam int unsigned AW = $clog2(ARCH_REGS);
  localparam int unsigned PW = $clog2(PHYS_REGS);
  localparam int unsigned CW = (NUM_CKPT > 1) ? $clog2(NUM_CKPT) : 1;

  typedef struct packed {
    logic          valid;
    logic [AW-1:0] idx;
  } a_reg_t;

  typedef struct packed {
    logic          valid;
    logic [PW-1:0] idx;
  } p_reg_t;

  typedef struct packed {
    logic          valid;
    logic [PW-1:0] idx;
    logic          ready;
  } p_src_t;

  typedef struct packed {
    logic   valid;
    a_reg_t rs1;
    a_reg_t rs2;
    a_reg_t rd;
    logic   is_branch;
  } dinstr_t;

  typedef struct packed {
    logic          valid;
    p_src_t        rs1;
    p_src_t        rs2;
    p_reg_t        rd;
    logic [PW-1:0] rd_old;
    logic [CW-1:0] ckpt_tag;
  } rinstr_t;

  typedef struct packed {
    logic valid;
    logic hit;
  } br_result_t;

endpackage

// File: rtl/rename_ckpt_preg_picker.sv
// Lowest-index set-bit priority encoder used to choose the next free physical register.
module preg_picker #(
  parameter  int unsigned N = 64,
  localparam int unsigned W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req_i,
  output logic [W-1:0] idx_o,
  output logic         valid_o
);

  // Scan from the top so the lowest set bit is the last to write.
  always_comb begin : pick
    idx_o   = '0;
    valid_o = 1'b0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_o   = W'(i);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rename_ckpt.sv
// Register rename with RAT, free/ready bitmaps and a circular FIFO of branch checkpoints.
module rename_ckpt
  import rename_pkg::dinstr_t, rename_pkg::rinstr_t, rename_pkg::p_reg_t, rename_pkg::br_result_t;
#(
  parameter  int unsigned ARCH_REGS = rename_pkg::ARCH_REGS,
  parameter  int unsigned PHYS_REGS = rename_pkg::PHYS_REGS,
  parameter  int unsigned NUM_CKPT  = rename_pkg::NUM_CKPT,
  localparam int unsigned PW        = $clog2(PHYS_REGS),
  localparam int unsigned CW        = (NUM_CKPT > 1) ? $clog2(NUM_CKPT) : 1,
  localparam int unsigned CNTW      = $clog2(NUM_CKPT + 1),
  localparam int unsigned FCW       = PW + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  dinstr_t          dinstr_i,
  output logic             dinstr_ready_o,
  output rinstr_t          rinstr_o,
  input  p_reg_t           wb_i,
  input  p_reg_t           free_i,
  input  br_result_t       br_result_i,
  output logic             ckpt_full_o,
  output logic [FCW-1:0]   free_cnt_o
);

  localparam logic [PHYS_REGS-1:0] FREE_RST =
    {{(PHYS_REGS - ARCH_REGS){1'b1}}, {ARCH_REGS{1'b0}}};

  logic [PW-1:0]        rat_q [ARCH_REGS];
  logic [PW-1:0]        rat_d [ARCH_REGS];
  logic [PHYS_REGS-1:0] free_q, free_d;
  logic [PHYS_REGS-1:0] ready_q, ready_d;
  logic [PW-1:0]        ckpt_rat_q [NUM_CKPT][ARCH_REGS];
  logic [PW-1:0]        ckpt_rat_d [NUM_CKPT][ARCH_REGS];
  logic [PHYS_REGS-1:0] ckpt_free_q [NUM_CKPT];
  logic [PHYS_REGS-1:0] ckpt_free_d [NUM_CKPT];
  logic [CW-1:0]        head_q, head_d, tail_q, tail_d;
  logic [CNTW-1:0]      count_q, count_d;
  logic [FCW-1:0]       free_cnt_q, free_cnt_d;

  logic [PW-1:0]        pick_idx;
  logic                 pick_valid;
  logic [PHYS_REGS-1:0] free_set;
  logic [NUM_CKPT-1:0]  occ;
  logic                 need_alloc, br_any, mispredict, br_hit, fire, alloc, br_fire;
  logic [PW-1:0]        rs1_p, rs2_p;
  logic                 rs1_rdy, rs2_rdy;

  function automatic logic [CW-1:0] ckpt_inc(input logic [CW-1:0] p);
    return (32'(p) == NUM_CKPT - 1) ? '0 : p + CW'(1);
  endfunction

  preg_picker #(.N(PHYS_REGS)) u_preg_picker (
    .req_i   (free_q),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  assign ckpt_full_o = (count_q == CNTW'(NUM_CKPT));
  assign free_cnt_o  = free_cnt_q;

  // A branch result with no checkpoint outstanding has nothing to act on.
  assign need_alloc = dinstr_i.rd.valid && (dinstr_i.rd.idx != '0);
  assign br_any     = br_result_i.valid && (count_q != '0);
  assign mispredict = br_any && !br_result_i.hit;
  assign br_hit     = br_any && br_result_i.hit;

  assign dinstr_ready_o = !(need_alloc && !pick_valid)
                       && !(dinstr_i.is_branch && ckpt_full_o)
                       && !mispredict;
  assign fire    = dinstr_i.valid && dinstr_ready_o;
  assign alloc   = fire && need_alloc;
  assign br_fire = fire && dinstr_i.is_branch;

  // Source lookup with same-cycle writeback bypass; x0 is always ready.
  assign rs1_p   = rat_q[dinstr_i.rs1.idx];
  assign rs2_p   = rat_q[dinstr_i.rs2.idx];
  assign rs1_rdy = ready_q[rs1_p] || (wb_i.valid && (wb_i.idx == rs1_p)) || (dinstr_i.rs1.idx == '0);
  assign rs2_rdy = ready_q[rs2_p] || (wb_i.valid && (wb_i.idx == rs2_p)) || (dinstr_i.rs2.idx == '0);

  always_comb begin : rename_out
    rinstr_o = '0;
    if (fire) begin
      rinstr_o.valid     = 1'b1;
      rinstr_o.rs1.valid = dinstr_i.rs1.valid;
      rinstr_o.rs1.idx   = rs1_p;
      rinstr_o.rs1.ready = rs1_rdy;
      rinstr_o.rs2.valid = dinstr_i.rs2.valid;
      rinstr_o.rs2.idx   = rs2_p;
      rinstr_o.rs2.ready = rs2_rdy;
      rinstr_o.rd.valid  = dinstr_i.rd.valid;
      if (need_alloc) begin
        rinstr_o.rd.idx = pick_idx;
        rinstr_o.rd_old = rat_q[dinstr_i.rd.idx];
      end
      if (dinstr_i.is_branch) begin
        rinstr_o.ckpt_tag = tail_q;
      end
    end
  end

  // p0 never enters the free list.
  always_comb begin : free_decode
    free_set = '0;
    if (free_i.valid && (free_i.idx != '0)) begin
      free_set[free_i.idx] = 1'b1;
    end
  end

  always_comb begin : ckpt_occupancy
    occ = '0;
    for (int unsigned s = 0; s < NUM_CKPT; s++) begin
      occ[s] = ((s + NUM_CKPT - 32'(head_q)) % NUM_CKPT) < 32'(count_q);
    end
  end

  always_comb begin : next_state
    rat_d       = rat_q;
    free_d      = free_q | free_set;
    ready_d     = ready_q;
    ckpt_rat_d  = ckpt_rat_q;
    ckpt_free_d = ckpt_free_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;

    if (wb_i.valid) begin
      ready_d[wb_i.idx] = 1'b1;
    end

    // Commits reach every live checkpoint so a later restore keeps them free.
    for (int unsigned s = 0; s < NUM_CKPT; s++) begin
      if (occ[s]) begin
        ckpt_free_d[s] = ckpt_free_q[s] | free_set;
      end
    end

    if (mispredict) begin
      rat_d   = ckpt_rat_q[head_q];
      free_d  = ckpt_free_q[head_q] | free_set;
      head_d  = tail_q;
      count_d = '0;
    end else begin
      if (br_hit) begin
        head_d  = ckpt_inc(head_q);
        count_d = count_q - CNTW'(1);
      end
      if (br_fire) begin
        ckpt_rat_d[tail_q]  = rat_q;
        ckpt_free_d[tail_q] = free_q | free_set;
        tail_d              = ckpt_inc(tail_q);
        count_d             = count_d + CNTW'(1);
      end
      if (alloc) begin
        rat_d[dinstr_i.rd.idx] = pick_idx;
        free_d[pick_idx]       = 1'b0;
        ready_d[pick_idx]      = 1'b0;
      end
    end

    free_cnt_d = '0;
    for (int unsigned i = 0; i < PHYS_REGS; i++) begin
      free_cnt_d = free_cnt_d + FCW'(free_d[i]);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin : state_regs
    if (!rst_ni) begin
      for (int unsigned i = 0; i < ARCH_REGS; i++) begin
        rat_q[i] <= PW'(i);
      end
      free_q  <= FREE_RST;
      ready_q <= ~FREE_RST;
      for (int unsigned c = 0; c < NUM_CKPT; c++) begin
        ckpt_free_q[c] <= '0;
        for (int unsigned a = 0; a < ARCH_REGS; a++) begin
          ckpt_rat_q[c][a] <= '0;
        end
      end
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      free_cnt_q <= FCW'(PHYS_REGS - ARCH_REGS);
    end else begin
      rat_q       <= rat_d;
      free_q      <= free_d;
      ready_q     <= ready_d;
      ckpt_rat_q  <= ckpt_rat_d;
      ckpt_free_q <= ckpt_free_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      free_cnt_q  <= free_cnt_d;
    end
  end

endmodule

// File: tb/tb_rename_ckpt.sv
// Directed and random checks of rename_ckpt against a queue-based reference model.
module tb_rename_ckpt;
  import rename_pkg::*;

  localparam int unsigned NA = ARCH_REGS;
  localparam int unsigned NP = PHYS_REGS;
  localparam int unsigned NC = NUM_CKPT;

  logic       clk_i  = 1'b0;
  logic       rst_ni = 1'b1;
  dinstr_t    dinstr_i;
  logic       dinstr_ready_o;
  rinstr_t    rinstr_o;
  p_reg_t     wb_i;
  p_reg_t     free_i;
  br_result_t br_result_i;
  logic       ckpt_full_o;
  logic [PW:0] free_cnt_o;

  rename_ckpt dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .dinstr_i       (dinstr_i),
    .dinstr_ready_o (dinstr_ready_o),
    .rinstr_o       (rinstr_o),
    .wb_i           (wb_i),
    .free_i         (free_i),
    .br_result_i    (br_result_i),
    .ckpt_full_o    (ckpt_full_o),
    .free_cnt_o     (free_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: map table, free/ready sets, checkpoints as a FIFO of snapshots.
  logic [NA-1:0][PW-1:0] m_rat;
  logic [NP-1:0]         m_free, m_ready;
  logic [NA-1:0][PW-1:0] ck_rat [$];
  logic [NP-1:0]         ck_free [$];
  int unsigned           m_tail;
  bit                    e_fire, e_need, e_misp;
  int unsigned           e_pick;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int unsigned i = 0; i < NA; i++) m_rat[i] = PW'(i);
    for (int unsigned i = 0; i < NP; i++) begin
      m_free[i]  = (i >= NA);
      m_ready[i] = (i < NA);
    end
    ck_rat.delete();
    ck_free.delete();
    m_tail = 0;
  endfunction

  task automatic check_outputs(input string tag);
    rinstr_t exp;
    bit      exp_rdy;
    int      nc;
    nc      = ck_rat.size();
    e_need  = dinstr_i.rd.valid && (dinstr_i.rd.idx != 0);
    e_misp  = br_result_i.valid && !br_result_i.hit && (nc > 0);
    exp_rdy = !(e_need && $countones(m_free) == 0) && !(dinstr_i.is_branch && nc == int'(NC)) && !e_misp;
    e_fire  = dinstr_i.valid && exp_rdy;
    e_pick  = 0;
    for (int unsigned i = 0; i < NP; i++) if (m_free[i]) begin e_pick = i; break; end
    exp = '0;
    if (e_fire) begin
      exp.valid     = 1'b1;
      exp.rs1.valid = dinstr_i.rs1.valid;
      exp.rs1.idx   = m_rat[dinstr_i.rs1.idx];
      exp.rs1.ready = m_ready[exp.rs1.idx] || (wb_i.valid && wb_i.idx == exp.rs1.idx) || (dinstr_i.rs1.idx == 0);
      exp.rs2.valid = dinstr_i.rs2.valid;
      exp.rs2.idx   = m_rat[dinstr_i.rs2.idx];
      exp.rs2.ready = m_ready[exp.rs2.idx] || (wb_i.valid && wb_i.idx == exp.rs2.idx) || (dinstr_i.rs2.idx == 0);
      exp.rd.valid  = dinstr_i.rd.valid;
      if (e_need) begin
        exp.rd.idx = PW'(e_pick);
        exp.rd_old = m_rat[dinstr_i.rd.idx];
      end
      if (dinstr_i.is_branch) exp.ckpt_tag = CW'(m_tail);
    end
    chk({tag, "_ready"}, 64'(dinstr_ready_o), 64'(exp_rdy));
    chk({tag, "_rinstr"}, 64'(rinstr_o), 64'(exp));
    chk({tag, "_full"}, 64'(ckpt_full_o), 64'(nc == int'(NC)));
    chk({tag, "_freecnt"}, 64'(free_cnt_o), 64'($countones(m_free)));
  endtask

  function automatic void model_update();
    logic [NP-1:0] fset;
    fset = '0;
    if (free_i.valid && free_i.idx != 0) fset[free_i.idx] = 1'b1;
    if (wb_i.valid) m_ready[wb_i.idx] = 1'b1;
    if (e_misp) begin
      m_rat  = ck_rat[0];
      m_free = ck_free[0] | fset;
      ck_rat.delete();
      ck_free.delete();
    end else begin
      m_free = m_free | fset;
      foreach (ck_free[k]) ck_free[k] = ck_free[k] | fset;
      if (br_result_i.valid && br_result_i.hit && ck_rat.size() > 0) begin
        void'(ck_rat.pop_front());
        void'(ck_free.pop_front());
      end
      if (e_fire && dinstr_i.is_branch) begin
        ck_rat.push_back(m_rat);
        ck_free.push_back(m_free);
        m_tail = (m_tail + 1) % NC;
      end
      if (e_fire && e_need) begin
        m_rat[dinstr_i.rd.idx] = PW'(e_pick);
        m_free[e_pick]  = 1'b0;
        m_ready[e_pick] = 1'b0;
      end
    end
  endfunction

  task automatic step(input string tag);
    #1;
    check_outputs(tag);
    @(posedge clk_i);
    model_update();
    @(negedge clk_i);
  endtask

  task automatic idle();
    dinstr_i    = '0;
    wb_i        = '0;
    free_i      = '0;
    br_result_i = '0;
  endtask

  task automatic drv(input int rs1, input int rs2, input int rd, input bit rdv, input bit br);
    dinstr_i.valid     = 1'b1;
    dinstr_i.rs1.valid = 1'b1;
    dinstr_i.rs1.idx   = AW'(rs1);
    dinstr_i.rs2.valid = 1'b1;
    dinstr_i.rs2.idx   = AW'(rs2);
    dinstr_i.rd.valid  = rdv;
    dinstr_i.rd.idx    = AW'(rd);
    dinstr_i.is_branch = br;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    #1;
    chk("rst_freecnt", 64'(free_cnt_o), 64'(NP - NA));
    chk("rst_full", 64'(ckpt_full_o), 64'(0));
    @(negedge clk_i);
    rst_ni = 1'b1;
    model_reset();
  endtask

  initial begin
    idle();
    @(negedge clk_i);
    do_reset();

    // add x5 <- x1, x2
    drv(1, 2, 5, 1, 0);
    #1;
    chk("add_rs1", 64'(rinstr_o.rs1.idx), 64'(1));
    chk("add_rs1_rdy", 64'(rinstr_o.rs1.ready), 64'(1));
    chk("add_rs2", 64'(rinstr_o.rs2.idx), 64'(2));
    chk("add_rd", 64'(rinstr_o.rd.idx), 64'(32));
    chk("add_rd_old", 64'(rinstr_o.rd_old), 64'(5));
    step("add");
    idle();
    #1;
    chk("add_freecnt", 64'(free_cnt_o), 64'(31));
    step("idle0");

    // x0 as destination and source
    drv(0, 0, 0, 1, 0);
    #1;
    chk("x0_rd", 64'(rinstr_o.rd.idx), 64'(0));
    chk("x0_rd_old", 64'(rinstr_o.rd_old), 64'(0));
    chk("x0_rs1", 64'(rinstr_o.rs1.idx), 64'(0));
    chk("x0_rs1_rdy", 64'(rinstr_o.rs1.ready), 64'(1));
    step("x0");
    idle();
    #1;
    chk("x0_freecnt", 64'(free_cnt_o), 64'(31));

    // consumer of x5 without and with same-cycle writeback of p32
    drv(5, 0, 0, 0, 0);
    #1;
    chk("cons_nobyp_rdy", 64'(rinstr_o.rs1.ready), 64'(0));
    step("cons_nobyp");
    drv(5, 0, 0, 0, 0);
    wb_i = '{valid: 1'b1, idx: PW'(32)};
    #1;
    chk("cons_byp_idx", 64'(rinstr_o.rs1.idx), 64'(32));
    chk("cons_byp_rdy", 64'(rinstr_o.rs1.ready), 64'(1));
    step("cons_byp");
    idle();

    // branch, x3 -> p33, mispredict with a same-cycle commit of p5
    drv(1, 2, 0, 0, 1);
    #1;
    chk("br_tag", 64'(rinstr_o.ckpt_tag), 64'(0));
    step("br");
    drv(1, 2, 3, 1, 0);
    #1;
    chk("x3_rd", 64'(rinstr_o.rd.idx), 64'(33));
    step("x3");
    drv(1, 2, 9, 1, 0);
    br_result_i = '{valid: 1'b1, hit: 1'b0};
    free_i      = '{valid: 1'b1, idx: PW'(5)};
    #1;
    chk("misp_ready", 64'(dinstr_ready_o), 64'(0));
    chk("misp_valid", 64'(rinstr_o.valid), 64'(0));
    step("misp");
    idle();
    drv(3, 0, 7, 1, 0);
    #1;
    chk("rest_rs1", 64'(rinstr_o.rs1.idx), 64'(3));
    chk("rest_rd", 64'(rinstr_o.rd.idx), 64'(5));
    chk("rest_freecnt", 64'(free_cnt_o), 64'(32));
    step("rest");

    // reset with a dispatch pending, then checkpoint wrap
    drv(1, 2, 4, 1, 0);
    do_reset();
    #1;
    chk("postrst_ready", 64'(dinstr_ready_o), 64'(1));
    chk("postrst_rd", 64'(rinstr_o.rd.idx), 64'(32));
    step("postrst");
    for (int k = 0; k < 4; k++) begin
      drv(1, 2, 0, 0, 1);
      #1;
      chk("ck_tag", 64'(rinstr_o.ckpt_tag), 64'(k));
      step("ck");
    end
    drv(1, 2, 0, 0, 1);
    #1;
    chk("ck5_stall", 64'(dinstr_ready_o), 64'(0));
    step("ck5_stall");
    br_result_i = '{valid: 1'b1, hit: 1'b1};
    step("ck5_hit");
    br_result_i = '0;
    #1;
    chk("ck5_ready", 64'(dinstr_ready_o), 64'(1));
    chk("ck5_tag", 64'(rinstr_o.ckpt_tag), 64'(0));
    step("ck5");

    // exhaust the free list
    idle();
    do_reset();
    for (int i = 0; i < 32; i++) begin
      drv(0, 0, 1 + (i % 31), 1, 0);
      step("fill");
    end
    drv(0, 0, 9, 1, 0);
    #1;
    chk("empty_ready", 64'(dinstr_ready_o), 64'(0));
    chk("empty_freecnt", 64'(free_cnt_o), 64'(0));
    step("empty");
    free_i = '{valid: 1'b1, idx: PW'(5)};
    step("empty_free");
    free_i = '0;
    #1;
    chk("refill_ready", 64'(dinstr_ready_o), 64'(1));
    chk("refill_rd", 64'(rinstr_o.rd.idx), 64'(5));
    step("refill");

    // random traffic
    idle();
    do_reset();
    for (int c = 0; c < 800; c++) begin
      dinstr_i.valid     = ($urandom_range(0, 3) != 0);
      dinstr_i.rs1.valid = 1'($urandom_range(0, 1));
      dinstr_i.rs1.idx   = AW'($urandom_range(0, NA - 1));
      dinstr_i.rs2.valid = 1'($urandom_range(0, 1));
      dinstr_i.rs2.idx   = AW'($urandom_range(0, NA - 1));
      dinstr_i.rd.valid  = ($urandom_range(0, 3) != 0);
      dinstr_i.rd.idx    = AW'($urandom_range(0, NA - 1));
      dinstr_i.is_branch = ($urandom_range(0, 4) == 0);
      wb_i.valid         = 1'($urandom_range(0, 1));
      wb_i.idx           = PW'($urandom_range(0, NP - 1));
      free_i.valid       = ($urandom_range(0, 2) != 0);
      free_i.idx         = PW'($urandom_range(0, NP - 1));
      br_result_i        = '0;
      if (ck_rat.size() > 0 && $urandom_range(0, 5) == 0) begin
        br_result_i.valid = 1'b1;
        br_result_i.hit   = ($urandom_range(0, 3) != 0);
      end
      step("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/rename_ckpt.md
RENAME_CKPT -- requirements
Module: rename_ckpt

Interface
REQ-001 Parameters (name, default, meaning):
- ARCH_REGS, 32, architectural registers.
- PHYS_REGS, 64, physical registers; must be greater than ARCH_REGS.
- NUM_CKPT, 4, branch checkpoint depth; must be at least 1.
- PW = clog2(PHYS_REGS); AW = clog2(ARCH_REGS); CW = clog2(NUM_CKPT).

REQ-002 Ports (name, direction, width, meaning):
- clk_i, in, 1, clock.
- rst_ni, in, 1, async reset, active-low.
- dinstr_i, in, dinstr_t, decoded instruction: valid, rs1/rs2/rd {valid, idx[AW]}, is_branch.
- dinstr_ready_o, out, 1, rename can accept this cycle.
- rinstr_o, out, rinstr_t, renamed instruction: valid, rs1/rs2 {valid, idx[PW], ready}, rd {valid, idx[PW]}, rd_old[PW], ckpt_tag[CW].
- wb_i, in, p_reg_t, writeback: valid, idx[PW]; marks the register ready.
- free_i, in, p_reg_t, in-order commit: valid, idx[PW]; returns a stale register to the free list.
- br_result_i, in, br_result_t, branch resolution: valid, hit; always refers to the oldest outstanding checkpoint.
- ckpt_full_o, out, 1, all NUM_CKPT checkpoints in use.
- free_cnt_o, out, PW+1, number of free physical registers.

Function
REQ-010 fire = dinstr_i.valid and dinstr_ready_o; state changes only on fire, wb, free or br_result; all state updates at posedge clk_i.
REQ-011 dinstr_ready_o SHALL be low when any of these holds:
- a free register is needed (rd.valid, rd.idx≠0) and free_cnt_o is 0;
- dinstr_i.is_branch and ckpt_full_o;
- br_result_i.valid and not hit (mispredict cycle).
REQ-012 Rename is combinational, latency 0: rinstr_o.valid = fire; all other rinstr_o fields are 0 when not fire.
REQ-013 Source mapping: rs.idx = RAT[arch idx]. rs.ready = ready_bit[preg], OR wb_i.valid with wb_i.idx equal to preg (same-cycle bypass), OR arch idx 0.
REQ-014 Destination allocation:
- New preg is the lowest-index set free bit, chosen by sub-module preg_picker.
- rd_old is RAT[rd] sampled before the update.
- Next edge: RAT[rd] becomes the new preg, its free bit clears, its ready bit clears.
REQ-015 x0: rd.idx 0 yields rd.idx output 0 and rd_old 0, allocates nothing and never writes RAT[0]; p0 is never on the free list and is always ready.
REQ-016 free_i.valid sets the free bit at the next edge. Freeing p0 or an already-free register is ignored.
REQ-017 wb_i.valid sets the ready bit. A wb and an allocation of the same preg in one cycle cannot occur legally; if they do, allocation wins.
REQ-018 Checkpoints form a circular FIFO with head, tail and count. Branch fire writes RAT and the free bitmap to slot tail, after applying the same-cycle free_i; rinstr_o.ckpt_tag = tail; tail increments.
- Checkpoint state excludes the branch's own rd; branches with rd are allowed.
REQ-019 free_i SHALL also set the freed bit in every occupied checkpoint slot, so reclaimed registers survive a later restore.
REQ-020 br_result_i with hit: pop head; count decrements.
REQ-021 br_result_i with not hit: RAT and free bitmap restore from slot head, with same-cycle free_i applied; all checkpoints clear (count 0, head = tail); the dispatch that cycle is blocked.
REQ-022 br_result_i.valid with count 0 is ignored.
REQ-023 Ready bits are not restored on mispredict; squashed registers re-enter the free list via restore and are cleared on reallocation.
REQ-024 free_cnt_o is the popcount of the live free bitmap, registered consistently with it.

Reset
REQ-030 On rst_ni low, asynchronously:
- RAT[i] = i;
- free bits set for ARCH_REGS..PHYS_REGS-1 only;
- ready bits set for 0..ARCH_REGS-1 only;
- checkpoint head, tail and count all 0;
- free_cnt_o = PHYS_REGS-ARCH_REGS.
REQ-031 Reset during a stalled or in-flight dispatch discards it; the first post-reset cycle has dinstr_ready_o = 1 and all combinational outputs follow REQ-012..014.

Structure
REQ-040 Package rename_pkg holds ARCH_REGS, PHYS_REGS, NUM_CKPT, dinstr_t, rinstr_t, p_reg_t and br_result_t; this extends the existing shared typedefs.
REQ-041 One sub-module, preg_picker: a parametrised lowest-set-bit priority encoder over PHYS_REGS with valid output.
REQ-042 Checkpoint slot storage uses flops; no memories.

Verification
REQ-050 After reset, rename add x5 <- x1, x2 → rs1 = p1 (ready), rs2 = p2 (ready), rd = p32, rd_old = p5; next cycle free_cnt_o = 31.
REQ-051 Allocate 32 destinations with no frees → the 33rd has dinstr_ready_o = 0. Then apply free_i = p5 → the stalled instruction fires with rd = p5.
REQ-052 Dispatch the producer of p32, then a consumer of x5 in the cycle wb_i = p32 → rs ready = 1 via bypass.
REQ-053 Branch (tag 0), then x3 → p33, then mispredict → RAT[3] = p3, p33 free, count 0, dispatch blocked that cycle. A free_i of p40 in the same cycle still leaves p40 free.
REQ-054 Four branches outstanding → fifth branch stalls; one hit → fifth branch fires with tag 0 after wrap.
REQ-055 rd = x0, and rs = x0 → no allocation, free_cnt_o unchanged, rs.idx 0 and ready.
